rv_multicycle_ctrl: RTL and testbench

Multi-cycle RV32I control unit. It sequences each instruction through fetch, decode, execute, memory and writeback states, using ready-handshakes to instruction and data memory. It drives the datapath select and enable strobes using the team's existing PCSel/RegWEn/BSel/ImmSel/ALUSel naming. It adds loads, stores, branches, jumps, LUI/AUIPC, a memory-stall timeout and a sticky trap.

---
 rtl/rv_multicycle_ctrl.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_rv_multicycle_ctrl.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB/TRAP sequencer with memory-stall timeout.
// Optional `CTRL_PERF_CNT_EN adds cycle_cnt / instret_cnt performance counters.
module rv_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             br_eq,
    input  logic             br_lt,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             MemRW,
    output logic             IRWEn,
    output logic             PCWEn,
    output logic             PCSel,
    output logic             RegWEn,
    output logic             ASel,
    output logic             BSel,
    output logic             BrUn,
    output logic [2:0]       ImmSel,
    output logic [3:0]       ALUSel,
    output logic [1:0]       WBSel,
    output logic             trap,
`ifdef CTRL_PERF_CNT_EN
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`else
    output logic [1:0]       trap_cause
`endif
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_e;

    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] WB_MEM = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_IMEM    = 2'd2;
    localparam logic [1:0] CAUSE_DMEM    = 2'd3;

    localparam logic [31:0] IR_NOP = 32'h0000_0013;

    // Stall counter is wide enough to hold MEM_TIMEOUT-1 without wrapping.
    localparam int SW = $clog2(MEM_TIMEOUT + 2);
    localparam logic [SW-1:0] TMO_LAST = (MEM_TIMEOUT > 0) ? SW'(MEM_TIMEOUT - 1) : '0;

    state_e          state_q;
    logic [SW-1:0]   stall_q;
    logic [6:0]      opc_q;
    logic [2:0]      f3_q;
    logic [6:0]      f7_q;
    logic            trap_q;
    logic [1:0]      cause_q;

    logic            is_load, is_store, is_branch, is_jump, legal, taken, tmo_hit;
    logic [3:0]      alu_f3;
    logic            unused_instr;

    // Only opcode/funct3/funct7 steer control; register and immediate fields go straight to the datapath.
    assign unused_instr = ^{instr[24:15], instr[11:7]};

    assign is_load   = (opc_q == OP_LOAD);
    assign is_store  = (opc_q == OP_STORE);
    assign is_branch = (opc_q == OP_BRANCH);
    assign is_jump   = (opc_q == OP_JAL) || (opc_q == OP_JALR);
    assign taken     = f3_q[2] ? (br_lt ^ f3_q[0]) : (br_eq ^ f3_q[0]);
    assign tmo_hit   = (MEM_TIMEOUT != 0) && (stall_q == TMO_LAST);

    always_comb begin
        unique case (f3_q)
            3'd0: alu_f3 = (opc_q == OP_REG && f7_q[5]) ? ALU_SUB : ALU_ADD;
            3'd1: alu_f3 = ALU_SLL;
            3'd2: alu_f3 = ALU_SLT;
            3'd3: alu_f3 = ALU_SLTU;
            3'd4: alu_f3 = ALU_XOR;
            3'd5: alu_f3 = f7_q[5] ? ALU_SRA : ALU_SRL;
            3'd6: alu_f3 = ALU_OR;
            default: alu_f3 = ALU_AND;
        endcase
    end

    always_comb begin
        legal = 1'b0;
        case (opc_q)
            OP_IMM:    legal = (f3_q == 3'd1) ? (f7_q == 7'h00) :
                               (f3_q == 3'd5) ? (f7_q == 7'h00 || f7_q == 7'h20) : 1'b1;
            OP_REG:    legal = (f7_q == 7'h00) ||
                               (f7_q == 7'h20 && (f3_q == 3'd0 || f3_q == 3'd5));
            OP_LOAD,
            OP_STORE:  legal = (f3_q == 3'd2);
            OP_BRANCH: legal = (f3_q[2:1] != 2'b01);
            OP_JALR:   legal = (f3_q == 3'd0);
            OP_JAL,
            OP_LUI,
            OP_AUIPC:  legal = 1'b1;
            default:   legal = 1'b0;
        endcase
    end

    // Datapath selects follow the IR so they are stable from DECODE through WB.
    always_comb begin
        ASel   = 1'b0;
        BSel   = 1'b1;
        ImmSel = IMM_I;
        ALUSel = ALU_ADD;
        WBSel  = WB_ALU;
        BrUn   = 1'b0;
        MemRW  = 1'b0;
        case (opc_q)
            OP_IMM:    ALUSel = alu_f3;
            OP_REG: begin
                BSel   = 1'b0;
                ALUSel = alu_f3;
            end
            OP_LOAD:   WBSel = WB_MEM;
            OP_STORE: begin
                ImmSel = IMM_S;
                MemRW  = 1'b1;
            end
            OP_BRANCH: begin
                ASel   = 1'b1;
                ImmSel = IMM_B;
                BrUn   = f3_q[1];
            end
            OP_JAL: begin
                ASel   = 1'b1;
                ImmSel = IMM_J;
                WBSel  = WB_PC4;
            end
            OP_JALR:   WBSel = WB_PC4;
            OP_LUI: begin
                ImmSel = IMM_U;
                ALUSel = ALU_PASSB;
            end
            OP_AUIPC: begin
                ASel   = 1'b1;
                ImmSel = IMM_U;
            end
            default: ;
        endcase
    end

    assign imem_req   = (state_q == S_FETCH);
    assign dmem_req   = (state_q == S_MEM);
    assign IRWEn      = imem_req & imem_ready;
    assign RegWEn     = (state_q == S_WB);
    assign trap       = trap_q;
    assign trap_cause = cause_q;

    always_comb begin
        PCWEn = 1'b0;
        PCSel = 1'b0;
        case (state_q)
            S_EXEC: begin
                PCWEn = is_branch;
                PCSel = is_branch & taken;
            end
            S_MEM:  PCWEn = is_store & dmem_ready;
            S_WB: begin
                PCWEn = 1'b1;
                PCSel = is_jump;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            stall_q <= '0;
            opc_q   <= IR_NOP[6:0];
            f3_q    <= IR_NOP[14:12];
            f7_q    <= IR_NOP[31:25];
            trap_q  <= 1'b0;
            cause_q <= 2'd0;
        end else begin
            // Any state entry clears the stall count; only an unanswered request keeps counting.
            stall_q <= '0;
            case (state_q)
                S_FETCH: begin
                    if (imem_ready) begin
                        opc_q   <= instr[6:0];
                        f3_q    <= instr[14:12];
                        f7_q    <= instr[31:25];
                        state_q <= S_DECODE;
                    end else if (tmo_hit) begin
                        state_q <= S_TRAP;
                        trap_q  <= 1'b1;
                        cause_q <= CAUSE_IMEM;
                    end else begin
                        stall_q <= stall_q + 1'b1;
                    end
                end
                S_DECODE: begin
                    if (legal) begin
                        state_q <= S_EXEC;
                    end else begin
                        state_q <= S_TRAP;
                        trap_q  <= 1'b1;
                        cause_q <= CAUSE_ILLEGAL;
                    end
                end
                S_EXEC: begin
                    if (is_branch)                 state_q <= S_FETCH;
                    else if (is_load || is_store)  state_q <= S_MEM;
                    else                           state_q <= S_WB;
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        state_q <= is_store ? S_FETCH : S_WB;
                    end else if (tmo_hit) begin
                        state_q <= S_TRAP;
                        trap_q  <= 1'b1;
                        cause_q <= CAUSE_DMEM;
                    end else begin
                        stall_q <= stall_q + 1'b1;
                    end
                end
                S_WB:    state_q <= S_FETCH;
                S_TRAP:  state_q <= S_TRAP;
                default: state_q <= S_FETCH;
            endcase
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_q, cycle_d, instret_q, instret_d;

    assign cycle_d   = (state_q != S_TRAP) ? cycle_q + 1'b1 : cycle_q;
    assign instret_d = PCWEn ? instret_q + 1'b1 : instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Randomized self-checking bench for rv_multicycle_ctrl against an instruction-level timing/select model.
module tb_rv_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        imem_ready = 1'b0, dmem_ready = 1'b0, br_eq = 1'b0, br_lt = 1'b0;
    logic        imem_req, dmem_req, MemRW, IRWEn, PCWEn, PCSel, RegWEn, ASel, BSel, BrUn, trap;
    logic [2:0]  ImmSel;
    logic [3:0]  ALUSel;
    logic [1:0]  WBSel, trap_cause;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    int checks = 0;
    int failures = 0;

    rv_multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .br_eq(br_eq), .br_lt(br_lt), .imem_req(imem_req), .dmem_req(dmem_req), .MemRW(MemRW),
        .IRWEn(IRWEn), .PCWEn(PCWEn), .PCSel(PCSel), .RegWEn(RegWEn), .ASel(ASel), .BSel(BSel),
        .BrUn(BrUn), .ImmSel(ImmSel), .ALUSel(ALUSel), .WBSel(WBSel), .trap(trap),
`ifdef CTRL_PERF_CNT_EN
        .trap_cause(trap_cause), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`else
        .trap_cause(trap_cause)
`endif
    );

    always #5 clk = ~clk;

    logic [12:0] obs_sel;
    assign obs_sel = {ASel, BSel, ImmSel, ALUSel, WBSel, BrUn, MemRW};

    typedef struct packed {
        logic        legal;
        logic [3:0]  base;
        logic        mem;
        logic        regw;
        logic        pcsel;
        logic [1:0]  wbsel;
        logic [12:0] sel;
    } exp_t;

    // Observations from the most recent exec_one
    int          o_cyc, o_ir, o_pcw, o_rw, o_dreq;
    logic        o_pcsel, o_done, o_trap, o_selchg;
    logic [1:0]  o_wbsel;
    logic [12:0] o_sel;

    function automatic logic [12:0] mk(input bit a, input bit b, input int imm, input int alu,
                                       input int wb, input bit brun, input bit mrw);
        return {a, b, imm[2:0], alu[3:0], wb[1:0], brun, mrw};
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic eq, input logic lt);
        exp_t e;
        logic [6:0] op, f7;
        logic [2:0] f3;
        int alu;
        bit tk;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        case (f3)
            3'd0: alu = (op == 7'h33 && f7 == 7'h20) ? 1 : 0;
            3'd1: alu = 2;
            3'd2: alu = 3;
            3'd3: alu = 4;
            3'd4: alu = 5;
            3'd5: alu = (f7 == 7'h20) ? 7 : 6;
            3'd6: alu = 8;
            default: alu = 9;
        endcase
        case (f3)
            3'd0: tk = eq;
            3'd1: tk = !eq;
            3'd4, 3'd6: tk = lt;
            3'd5, 3'd7: tk = !lt;
            default: tk = 0;
        endcase
        e = '0; e.legal = 1; e.base = 4; e.regw = 1; e.wbsel = 1;
        case (op)
            7'h13: begin
                e.sel = mk(0, 1, 0, alu, 1, 0, 0);
                e.legal = !(f3 == 1 && f7 != 0) && !(f3 == 5 && f7 != 0 && f7 != 7'h20);
            end
            7'h33: begin
                e.sel = mk(0, 0, 0, alu, 1, 0, 0);
                e.legal = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
            end
            7'h03: begin
                e.sel = mk(0, 1, 0, 0, 0, 0, 0); e.base = 5; e.mem = 1; e.wbsel = 0;
                e.legal = (f3 == 2);
            end
            7'h23: begin
                e.sel = mk(0, 1, 1, 0, 1, 0, 1); e.mem = 1; e.regw = 0;
                e.legal = (f3 == 2);
            end
            7'h63: begin
                e.sel = mk(1, 1, 2, 0, 1, (f3 == 6 || f3 == 7), 0); e.base = 3; e.regw = 0;
                e.pcsel = tk; e.legal = !(f3 == 2 || f3 == 3);
            end
            7'h6F: begin e.sel = mk(1, 1, 4, 0, 2, 0, 0); e.pcsel = 1; e.wbsel = 2; end
            7'h67: begin
                e.sel = mk(0, 1, 0, 0, 2, 0, 0); e.pcsel = 1; e.wbsel = 2;
                e.legal = (f3 == 0);
            end
            7'h37: e.sel = mk(0, 1, 3, 10, 1, 0, 0);
            7'h17: e.sel = mk(1, 1, 3, 0, 1, 0, 0);
            default: e.legal = 0;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_legal();
        logic [31:0] w;
        logic [2:0]  bf [6];
        bit          hi;
        int          k;
        bf = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        w  = $urandom;
        hi = 1'($urandom);
        k  = $urandom_range(0, 8);
        case (k)
            0: begin
                w[6:0] = 7'h13;
                if (w[14:12] == 3'd1) w[31:25] = 7'h00;
                else if (w[14:12] == 3'd5) w[31:25] = hi ? 7'h20 : 7'h00;
            end
            1: begin
                w[6:0] = 7'h33;
                w[31:25] = ((w[14:12] == 3'd0 || w[14:12] == 3'd5) && hi) ? 7'h20 : 7'h00;
            end
            2: begin w[6:0] = 7'h03; w[14:12] = 3'd2; end
            3: begin w[6:0] = 7'h23; w[14:12] = 3'd2; end
            4: begin w[6:0] = 7'h63; w[14:12] = bf[$urandom_range(0, 5)]; end
            5: w[6:0] = 7'h6F;
            6: begin w[6:0] = 7'h67; w[14:12] = 3'd0; end
            7: w[6:0] = 7'h37;
            default: w[6:0] = 7'h17;
        endcase
        return w;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Runs one instruction from FETCH until its PC write (or a trap); call just after a rising edge.
    task automatic exec_one(input logic [31:0] ins, input int iw, input int dw,
                            input logic eq, input logic lt, input bit noise);
        int iwc, dwc;
        bit seen_ir, sel_rec;
        o_cyc = 0; o_ir = 0; o_pcw = 0; o_rw = 0; o_dreq = 0;
        o_pcsel = 0; o_done = 0; o_trap = 0; o_selchg = 0; o_wbsel = 0; o_sel = '0;
        iwc = 0; dwc = 0; seen_ir = 0; sel_rec = 0;
        br_eq = eq; br_lt = lt;
        for (int k = 0; k < 40 && !o_done; k++) begin
            instr      = (imem_req || !noise) ? ins : $urandom;
            imem_ready = imem_req ? (iwc >= iw) : noise;
            dmem_ready = dmem_req ? (dwc >= dw) : (noise && 1'($urandom));
            @(negedge clk);
            o_cyc++;
            if (seen_ir && !trap) begin
                if (!sel_rec) begin o_sel = obs_sel; sel_rec = 1; end
                else if (obs_sel !== o_sel) o_selchg = 1;
            end
            if (IRWEn) begin o_ir++; seen_ir = 1; end
            if (RegWEn) begin o_rw++; o_wbsel = WBSel; end
            if (dmem_req) o_dreq++;
            if (imem_req && !imem_ready) iwc++;
            if (dmem_req && !dmem_ready) dwc++;
            if (PCWEn) begin o_pcw++; o_pcsel = PCSel; o_done = 1; end
            if (trap) begin o_trap = 1; o_done = 1; end
            @(posedge clk);
            #1;
        end
        imem_ready = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({imem_req, dmem_req, IRWEn, PCWEn, RegWEn, trap, trap_cause} !== 8'b1000_0000) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=10000000",
                     {imem_req, dmem_req, IRWEn, PCWEn, RegWEn, trap, trap_cause});
        end
        checks++;
        if (obs_sel !== mk(0, 1, 0, 0, 1, 0, 0)) begin
            failures++; $display("FAIL reset_nop_selects got=%h exp=%h", obs_sel, mk(0, 1, 0, 0, 1, 0, 0));
        end
`ifdef CTRL_PERF_CNT_EN
        checks++;
        if (cycle_cnt !== 0 || instret_cnt !== 0) begin
            failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", cycle_cnt, instret_cnt);
        end
`endif
    endtask

    task automatic test_directed();
        do_reset();
        exec_one(32'h00500093, 0, 0, 0, 0, 0);   // addi x1,x0,5
        checks++;
        if (o_cyc !== 4 || o_rw !== 1 || o_pcsel !== 0 || o_wbsel !== 1) begin
            failures++; $display("FAIL addi_timing cyc=%0d rw=%0d pcsel=%0d wb=%0d exp=4/1/0/1",
                                 o_cyc, o_rw, o_pcsel, o_wbsel);
        end
        checks++;
        if (o_sel !== mk(0, 1, 0, 0, 1, 0, 0)) begin
            failures++; $display("FAIL addi_sel got=%h exp=%h", o_sel, mk(0, 1, 0, 0, 1, 0, 0));
        end
        exec_one(32'h40208133, 0, 0, 0, 0, 0);   // sub x2,x1,x2
        checks++;
        if (o_cyc !== 4 || o_sel !== mk(0, 0, 0, 1, 1, 0, 0)) begin
            failures++; $display("FAIL sub cyc=%0d sel=%h exp=4/%h", o_cyc, o_sel, mk(0, 0, 0, 1, 1, 0, 0));
        end
        exec_one(32'h0000A183, 0, 2, 0, 0, 0);   // lw x3,0(x1), two dmem waits
        checks++;
        if (o_cyc !== 7 || o_dreq !== 3 || o_wbsel !== 0 || o_rw !== 1) begin
            failures++; $display("FAIL lw_wait cyc=%0d dreq=%0d wb=%0d rw=%0d exp=7/3/0/1",
                                 o_cyc, o_dreq, o_wbsel, o_rw);
        end
        exec_one(32'h00000463, 0, 0, 1, 0, 0);   // beq x0,x0,8 taken
        checks++;
        if (o_cyc !== 3 || o_pcsel !== 1 || o_rw !== 0 || o_sel !== mk(1, 1, 2, 0, 1, 0, 0)) begin
            failures++; $display("FAIL beq cyc=%0d pcsel=%0d rw=%0d sel=%h exp=3/1/0/%h",
                                 o_cyc, o_pcsel, o_rw, o_sel, mk(1, 1, 2, 0, 1, 0, 0));
        end
        exec_one(32'h00000463, 0, 0, 0, 1, 0);   // beq not taken
        checks++;
        if (o_cyc !== 3 || o_pcsel !== 0) begin
            failures++; $display("FAIL beq_nt cyc=%0d pcsel=%0d exp=3/0", o_cyc, o_pcsel);
        end
    endtask

    task automatic test_boundary();
        do_reset();
        exec_one(32'h00500093, 3, 0, 0, 0, 0);   // 3 imem waits: ready wins at the limit
        checks++;
        if (o_cyc !== 7 || o_trap !== 0 || o_pcw !== 1) begin
            failures++; $display("FAIL imem_3wait cyc=%0d trap=%0d pcw=%0d exp=7/0/1", o_cyc, o_trap, o_pcw);
        end
        exec_one(32'h0020A223, 0, 3, 0, 0, 0);   // sw with 3 dmem waits
        checks++;
        if (o_cyc !== 7 || o_trap !== 0 || o_dreq !== 4 || o_rw !== 0) begin
            failures++; $display("FAIL sw_3wait cyc=%0d trap=%0d dreq=%0d rw=%0d exp=7/0/4/0",
                                 o_cyc, o_trap, o_dreq, o_rw);
        end
    endtask

    task automatic test_random();
        logic [31:0] ins;
        int iw, dw, total, nins, expc;
        logic eq, lt;
        bit nz;
        exp_t e;
        do_reset();
        total = 0; nins = 0;
        for (int n = 0; n < 150; n++) begin
            ins = rand_legal();
            iw = $urandom_range(0, 3); dw = $urandom_range(0, 3);
            eq = 1'($urandom); lt = 1'($urandom); nz = 1'($urandom);
            e = model(ins, eq, lt);
            exec_one(ins, iw, dw, eq, lt, nz);
            total += o_cyc; nins++;
            expc = int'(e.base) + iw + (e.mem ? dw : 0);
            checks++;
            if (!o_done || o_trap || o_cyc != expc) begin
                failures++; $display("FAIL rand_cycles ins=%h done=%0d trap=%0d got=%0d exp=%0d",
                                     ins, o_done, o_trap, o_cyc, expc);
            end
            checks++;
            if (o_ir !== 1 || o_pcw !== 1 || o_rw !== int'(e.regw) || o_dreq !== (e.mem ? dw + 1 : 0)) begin
                failures++; $display("FAIL rand_strobes ins=%h ir/pcw/rw/dreq=%0d/%0d/%0d/%0d exp=1/1/%0d/%0d",
                                     ins, o_ir, o_pcw, o_rw, o_dreq, e.regw, e.mem ? dw + 1 : 0);
            end
            checks++;
            if (o_pcsel !== e.pcsel || (e.regw && o_wbsel !== e.wbsel)) begin
                failures++; $display("FAIL rand_pcsel_wb ins=%h pcsel=%0d wb=%0d exp=%0d/%0d",
                                     ins, o_pcsel, o_wbsel, e.pcsel, e.wbsel);
            end
            checks++;
            if (o_sel !== e.sel || o_selchg) begin
                failures++; $display("FAIL rand_sel ins=%h got=%h changed=%0d exp=%h", ins, o_sel, o_selchg, e.sel);
            end
        end
`ifdef CTRL_PERF_CNT_EN
        checks++;
        if (cycle_cnt !== 32'(total) || instret_cnt !== 32'(nins)) begin
            failures++; $display("FAIL perf_counters got=%0d/%0d exp=%0d/%0d", cycle_cnt, instret_cnt, total, nins);
        end
`endif
    endtask

    task automatic test_illegal();
        logic [31:0] bad [10];
        int iw, zero_bad;
        bad = '{32'h00000000, 32'h0000000F, 32'h00000073, 32'h00001083, 32'h00001023,
                32'h02000033, 32'h40001013, 32'h00002063, 32'h00001067, 32'h40002033};
        for (int i = 0; i < 10; i++) begin
            do_reset();
            iw = $urandom_range(0, 3);
            exec_one(bad[i], iw, 0, 0, 0, 0);
            checks++;
            if (o_trap !== 1 || trap_cause !== 2'd1 || o_cyc !== iw + 3 || o_pcw !== 0 || o_rw !== 0) begin
                failures++; $display("FAIL illegal ins=%h trap=%0d cause=%0d cyc=%0d pcw=%0d rw=%0d exp=1/1/%0d/0/0",
                                     bad[i], o_trap, trap_cause, o_cyc, o_pcw, o_rw, iw + 3);
            end
            if (i == 0) begin
                zero_bad = 0;
                for (int k = 0; k < 20; k++) begin
                    imem_ready = 1'($urandom); dmem_ready = 1'($urandom);
                    @(negedge clk);
                    if ({imem_req, dmem_req, IRWEn, PCWEn, RegWEn} !== 5'b0 || trap !== 1) zero_bad++;
                    @(posedge clk);
                    #1;
                end
                checks++;
                if (zero_bad != 0) begin
                    failures++; $display("FAIL trap_quiet bad_cycles=%0d exp=0", zero_bad);
                end
                do_reset();
                checks++;
                if (trap !== 0 || trap_cause !== 0 || imem_req !== 1) begin
                    failures++; $display("FAIL trap_reset trap=%0d cause=%0d imem_req=%0d exp=0/0/1",
                                         trap, trap_cause, imem_req);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int cyc, reqc;
        do_reset();
        cyc = 0; reqc = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            cyc++;
            if (imem_req) reqc++;
            if (trap) break;
            @(posedge clk);
            #1;
        end
        checks++;
        if (trap !== 1 || trap_cause !== 2'd2 || cyc !== 5 || reqc !== 4) begin
            failures++; $display("FAIL imem_timeout trap=%0d cause=%0d cyc=%0d req=%0d exp=1/2/5/4",
                                 trap, trap_cause, cyc, reqc);
        end
`ifdef CTRL_PERF_CNT_EN
        repeat (10) @(negedge clk);
        checks++;
        if (cycle_cnt !== 4 || instret_cnt !== 0) begin
            failures++; $display("FAIL cycle_freeze got=%0d/%0d exp=4/0", cycle_cnt, instret_cnt);
        end
`endif
        @(posedge clk);
        #1;
        do_reset();
        exec_one(32'h0000A183, 0, 100, 0, 0, 0);   // lw, dmem never ready
        checks++;
        if (o_trap !== 1 || trap_cause !== 2'd3 || o_dreq !== 4 || o_cyc !== 8 || o_rw !== 0) begin
            failures++; $display("FAIL dmem_timeout trap=%0d cause=%0d dreq=%0d cyc=%0d rw=%0d exp=1/3/4/8/0",
                                 o_trap, trap_cause, o_dreq, o_cyc, o_rw);
        end
    endtask

    task automatic test_reset_abort();
        do_reset();
        instr = 32'h00500093; imem_ready = 1'b1;
        @(posedge clk); #1 imem_ready = 1'b0;   // DECODE
        @(posedge clk); #1;                       // EXEC
        @(posedge clk); #1;                       // WB: RegWEn/PCWEn high now
        rst_n = 1'b0;
        #1;
        checks++;
        if ({RegWEn, PCWEn, IRWEn, dmem_req, imem_req} !== 5'b00001) begin
            failures++; $display("FAIL reset_abort got=%b exp=00001", {RegWEn, PCWEn, IRWEn, dmem_req, imem_req});
        end
        @(posedge clk); #1 rst_n = 1'b1;
        exec_one(32'h00500093, 0, 0, 0, 0, 0);
        checks++;
        if (o_cyc !== 4 || o_rw !== 1 || o_trap !== 0) begin
            failures++; $display("FAIL after_abort cyc=%0d rw=%0d trap=%0d exp=4/1/0", o_cyc, o_rw, o_trap);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_boundary();
        test_random();
        test_illegal();
        test_timeout();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
